countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
Loadable down-counter with terminal-count detection. It is the decrementing counterpart to the team's T-flip-flop up-counter chain.
- Counts a programmed value down to zero on enable ticks, then pulses DONE.
- Optional auto-reload for periodic ticks.
- Exposes a combinational borrow-out so instances cascade into wider or multi-stage timers, the same way the up-counters chain their carry.

Parameters:
WIDTH, 16, counter and load-value width in bits (minimum 4, multiple of 4).
PRESCALE, 4, EN ticks per decrement; used only when COUNTDOWN_PRESCALER_EN is defined; must be ≥2.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RST  input  1  synchronous reset, active-high.
LOAD  input  1  single-cycle strobe: capture LOAD_VAL and start.
LOAD_VAL  input  WIDTH  start/reload value.
RELOAD  input  1  1 = auto-reload on expiry; 0 = one-shot. Sampled each cycle.
ABORT  input  1  stop and clear without DONE.
EN  input  1  decrement tick / borrow-in from a lower stage.
COUNT_VAL  output  WIDTH  current count, registered.
BUSY  output  1  registered; 1 while in RUN.
DONE  output  1  registered one-cycle pulse on expiry.
BORROW_OUT  output  1  combinational; the terminal tick, for cascading.

Behaviour:
- Interface: one clock, CLK. RST is synchronous and active-high.
- States: IDLE, RUN. There are only two; expiry is signalled by the DONE pulse, not by a state.
- Reset (RST=1 at an edge): state=IDLE, COUNT_VAL=0, reload register=0, BUSY=0, DONE=0, prescaler=0. Reset mid-run produces no DONE.
- Priority per edge: RST > ABORT > LOAD > EN.
- ABORT (any state): state=IDLE, COUNT_VAL=0, DONE=0.
- LOAD (any state, including RUN as a restart):
  - reload register <= LOAD_VAL; COUNT_VAL <= LOAD_VAL.
  - If LOAD_VAL≠0: state=RUN.
  - If LOAD_VAL=0: state=IDLE and DONE=1 on the next cycle (immediate expiry).
  - EN in the LOAD cycle is ignored.
- RUN with EN=1:
  - COUNT_VAL>1: COUNT_VAL decrements by 1.
  - COUNT_VAL==1: this is the terminal tick, and DONE=1 in the following cycle.
    - RELOAD=1: COUNT_VAL <= reload register; stay in RUN.
    - RELOAD=0: COUNT_VAL <= 0; state=IDLE.
- RUN with EN=0: hold all state.
- IDLE: EN is ignored. COUNT_VAL never underflows or wraps below 0.
- BORROW_OUT = (state==RUN) & EN & (COUNT_VAL==1), ANDed with the prescaler terminal when the feature is enabled. It has no register stage, so cascaded stages decrement on the same edge.
- Period in reload mode equals the reload value, in EN ticks.
- Latency: LOAD→COUNT_VAL valid is 1 cycle. Terminal tick→DONE is 1 cycle. BUSY falls in the same cycle DONE rises (one-shot mode).
- Arithmetic: unsigned modulo-2^WIDTH. A decrement is never applied at 0.

Optional Feature:
COUNTDOWN_PRESCALER_EN.
- Defined: an internal counter of width clog2(PRESCALE) counts EN ticks in RUN. COUNT_VAL decrements, and BORROW_OUT is qualified, only on every PRESCALE-th EN tick. The prescaler clears on RST, LOAD, ABORT and expiry.
- Undefined: no prescaler logic is instantiated, every EN tick in RUN decrements, and PRESCALE is ignored.

Decomposition:
- Shared package countdown_pkg holds:
  - the state enum (IDLE, RUN);
  - a localparam for the minimum WIDTH;
  - a function computing the prescaler width.
- Sub-module down_count_slice is natural: a 4-bit decrementing slice with borrow-in/borrow-out, zero detect and parallel load. It mirrors the 4-bit up-counter slice. The top instantiates WIDTH/4 slices in a borrow chain and owns the FSM, reload register and DONE/BUSY registers.

Test Plan:
1. RST; RELOAD=0; LOAD_VAL=5 with LOAD pulse; EN=1 held → COUNT_VAL 5,4,3,2,1,0. BORROW_OUT high only while COUNT_VAL=1. DONE high for exactly one cycle as COUNT_VAL reaches 0, with BUSY falling in that same cycle.
2. RELOAD=1, LOAD_VAL=3, EN=1 → COUNT_VAL 3,2,1,3,2,1,…; DONE pulses every 3 cycles; BUSY stays 1.
3. LOAD_VAL=0 with LOAD pulse → DONE pulses the next cycle; BUSY stays 0; COUNT_VAL=0. Then EN toggled in IDLE → COUNT_VAL remains 0.
4. LOAD_VAL=4, EN alternating 1/0 → COUNT_VAL holds on EN=0 cycles; DONE after 4 EN=1 ticks. ABORT and LOAD in the same cycle at COUNT_VAL=2 → IDLE, COUNT_VAL=0, no DONE.
5. Cascade two WIDTH=4 instances (upper EN = lower BORROW_OUT, both RELOAD=1); lower LOAD_VAL=15, upper LOAD_VAL=2 → upper decrements once per 15 cycles and its DONE fires at cycle 30.
6. RST asserted at COUNT_VAL=2 mid-run → next cycle COUNT_VAL=0, BUSY=0, no DONE. With COUNTDOWN_PRESCALER_EN and PRESCALE=4, LOAD_VAL=2, EN=1 held → DONE after 8 EN ticks.

Source files
------------

// File: rtl/countdown_pkg.sv
// countdown_pkg: shared types and helpers for the countdown timer.
//   state_e          - two-state control FSM encoding (IDLE, RUN)
//   MIN_WIDTH        - smallest supported counter width (one 4-bit slice)
//   prescale_width() - width of the optional EN-tick prescaler counter
package countdown_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int MIN_WIDTH = 4;

    // Never returns 0 so the prescaler register always has a legal width.
    function automatic int prescale_width(input int prescale);
        if (prescale < 2) begin
            return 1;
        end else begin
            return $clog2(prescale);
        end
    endfunction

endpackage

// File: rtl/down_count_slice.sv
// down_count_slice: 4-bit decrementing counter slice, the building block of
// the countdown timer's borrow chain.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset (count -> 0)
//   load       - parallel load strobe, wins over decrement
//   load_val   - 4-bit value captured on load
//   borrow_in  - decrement this slice by one
//   count      - registered slice value
//   zero       - slice value is 0
//   borrow_out - this slice wraps 0 -> F, so the next slice must decrement
module down_count_slice (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       borrow_in,
    output logic [3:0] count,
    output logic       zero,
    output logic       borrow_out
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // Next slice value: load first, then decrement on borrow-in.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (borrow_in) begin
            count_d = count_q - 4'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Slice value register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign zero       = (count_q == 4'd0);
    assign borrow_out = borrow_in & zero;

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with terminal-count detection,
// optional auto-reload and a combinational borrow-out for cascading.
// Optional feature macro: COUNTDOWN_PRESCALER_EN (EN-tick prescaler by
// PRESCALE); when undefined every EN tick in RUN decrements.
// Ports:
//   CLK        - clock, rising edge
//   RST        - synchronous active-high reset
//   LOAD       - capture LOAD_VAL and (re)start; LOAD_VAL=0 expires at once
//   LOAD_VAL   - start / reload value
//   RELOAD     - 1: auto-reload on expiry, 0: one-shot
//   ABORT      - stop and clear without DONE
//   EN         - decrement tick / borrow-in from a lower stage
//   COUNT_VAL  - registered current count
//   BUSY       - registered, 1 while in RUN
//   DONE       - registered one-cycle expiry pulse
//   BORROW_OUT - combinational terminal tick for the next stage's EN
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic             RELOAD,
    input  logic             ABORT,
    input  logic             EN,
    output logic [WIDTH-1:0] COUNT_VAL,
    output logic             BUSY,
    output logic             DONE,
    output logic             BORROW_OUT
);

    localparam int NSLICE = (WIDTH < MIN_WIDTH) ? 1 : (WIDTH / 4);
    localparam logic [WIDTH-1:0] COUNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e             state_q;
    state_e             state_d;
    logic [WIDTH-1:0]   reload_q;
    logic [WIDTH-1:0]   reload_d;
    logic               busy_q;
    logic               busy_d;
    logic               done_q;
    logic               done_d;

    logic [WIDTH-1:0]   count_s;
    logic [NSLICE-1:0]  zero_s;
    logic [NSLICE:0]    borrow_s;
    logic               borrow_top_unused_s;
    logic               slice_load_s;
    logic [WIDTH-1:0]   slice_val_s;

    logic               count_one_s;
    logic               count_zero_s;
    logic               load_zero_s;
    logic               run_en_s;
    logic               presc_tick_s;
    logic               terminal_s;
    logic               dec_s;

    assign count_one_s  = (count_s == COUNT_ONE);
    assign count_zero_s = &zero_s;
    assign load_zero_s  = (LOAD_VAL == {WIDTH{1'b0}});

    // An EN tick only counts in RUN when nothing of higher priority happens.
    assign run_en_s   = (state_q == RUN) & EN & ~ABORT & ~LOAD;
    assign terminal_s = run_en_s & presc_tick_s & count_one_s;
    // The zero guard keeps the counter from ever wrapping below 0.
    assign dec_s      = run_en_s & presc_tick_s & ~count_one_s & ~count_zero_s;

    // BORROW_OUT is deliberately not masked by LOAD/ABORT: it reflects the
    // raw terminal tick so a cascaded stage decrements on the same edge.
    assign BORROW_OUT = (state_q == RUN) & EN & count_one_s & presc_tick_s;

`ifdef COUNTDOWN_PRESCALER_EN
    localparam int PW = prescale_width(PRESCALE);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          presc_clr_s;

    assign presc_tick_s = (presc_q == PW'(PRESCALE - 1));
    assign presc_clr_s  = ABORT | LOAD | terminal_s;

    // Prescaler next value: counts RUN EN ticks modulo PRESCALE.
    always_comb begin
        presc_d = presc_q;
        if (presc_clr_s) begin
            presc_d = {PW{1'b0}};
        end else if (run_en_s) begin
            if (presc_tick_s) begin
                presc_d = {PW{1'b0}};
            end else begin
                presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
            end
        end else begin
            presc_d = presc_q;
        end
    end

    // Prescaler register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            presc_q <= {PW{1'b0}};
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    // PRESCALE has no effect without the prescaler.
    localparam int PRESCALE_UNUSED = PRESCALE;

    assign presc_tick_s = 1'b1;
`endif

    // Slice load control: ABORT and one-shot expiry clear, LOAD and
    // reload expiry restart from a value.
    always_comb begin
        slice_load_s = 1'b0;
        slice_val_s  = {WIDTH{1'b0}};
        reload_d     = reload_q;
        if (ABORT) begin
            slice_load_s = 1'b1;
        end else if (LOAD) begin
            slice_load_s = 1'b1;
            slice_val_s  = LOAD_VAL;
            reload_d     = LOAD_VAL;
        end else if (terminal_s) begin
            slice_load_s = 1'b1;
            slice_val_s  = RELOAD ? reload_q : {WIDTH{1'b0}};
        end else begin
            slice_load_s = 1'b0;
        end
    end

    assign borrow_s[0] = dec_s;

    genvar gi;
    generate
        for (gi = 0; gi < NSLICE; gi++) begin : g_slice
            down_count_slice u_slice (
                .clk        (CLK),
                .rst        (RST),
                .load       (slice_load_s),
                .load_val   (slice_val_s[4*gi +: 4]),
                .borrow_in  (borrow_s[gi]),
                .count      (count_s[4*gi +: 4]),
                .zero       (zero_s[gi]),
                .borrow_out (borrow_s[gi+1])
            );
        end
    endgenerate

    // The top slice never borrows because decrements are never applied at 0.
    assign borrow_top_unused_s = borrow_s[NSLICE];

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ABORT) begin
                    state_d = IDLE;
                end else if (LOAD && !load_zero_s) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (ABORT) begin
                    state_d = IDLE;
                end else if (LOAD) begin
                    state_d = load_zero_s ? IDLE : RUN;
                end else if (terminal_s && !RELOAD) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: DONE on expiry or on a zero load, BUSY follows RUN.
    always_comb begin
        done_d = (~ABORT & LOAD & load_zero_s) | terminal_s;
        busy_d = (state_d == RUN);
    end

    // State, reload and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            reload_q <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign COUNT_VAL = count_s;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    localparam int W = 16;
`ifdef COUNTDOWN_PRESCALER_EN
    localparam int PS = 4;
`else
    localparam int PS = 1;
`endif

    logic clk;
    logic rst, load, reload, abort, en;
    logic [W-1:0] load_val;
    logic [W-1:0] count_val;
    logic busy, done, borrow;

    logic c_rst, c_load;
    logic [3:0] c_lo_val, c_up_val;
    logic [3:0] lo_count, up_count;
    logic lo_busy, lo_done, lo_borrow, up_busy, up_done, up_borrow;

    int checks = 0;
    int passed = 0;

    countdown_timer #(.WIDTH(W), .PRESCALE(4)) dut (
        .CLK(clk), .RST(rst), .LOAD(load), .LOAD_VAL(load_val), .RELOAD(reload),
        .ABORT(abort), .EN(en), .COUNT_VAL(count_val), .BUSY(busy), .DONE(done),
        .BORROW_OUT(borrow)
    );

    countdown_timer #(.WIDTH(4), .PRESCALE(4)) u_lo (
        .CLK(clk), .RST(c_rst), .LOAD(c_load), .LOAD_VAL(c_lo_val), .RELOAD(1'b1),
        .ABORT(1'b0), .EN(1'b1), .COUNT_VAL(lo_count), .BUSY(lo_busy), .DONE(lo_done),
        .BORROW_OUT(lo_borrow)
    );

    countdown_timer #(.WIDTH(4), .PRESCALE(4)) u_up (
        .CLK(clk), .RST(c_rst), .LOAD(c_load), .LOAD_VAL(c_up_val), .RELOAD(1'b1),
        .ABORT(1'b0), .EN(lo_borrow), .COUNT_VAL(up_count), .BUSY(up_busy), .DONE(up_done),
        .BORROW_OUT(up_borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: running flag, count, reload value, DONE, EN-tick phase.
    typedef struct {
        bit run;
        int count;
        int rld;
        bit done;
        int pc;
    } mdl_t;

    mdl_t m, c_lo, c_up;

    function automatic mdl_t mdl_next(mdl_t s, bit r, bit ab, bit ld, int lv, bit rl, bit e);
        mdl_t n;
        n = s;
        n.done = 1'b0;
        if (r) begin
            n.run = 1'b0; n.count = 0; n.rld = 0; n.pc = 0;
        end else if (ab) begin
            n.run = 1'b0; n.count = 0; n.pc = 0;
        end else if (ld) begin
            n.rld = lv; n.count = lv; n.run = (lv != 0); n.done = (lv == 0); n.pc = 0;
        end else if (s.run && e) begin
            if (s.pc < PS - 1) begin
                n.pc = s.pc + 1;
            end else begin
                n.pc = 0;
                if (s.count == 1) begin
                    n.done = 1'b1;
                    if (rl) n.count = s.rld;
                    else begin n.count = 0; n.run = 1'b0; end
                end else begin
                    n.count = s.count - 1;
                end
            end
        end
        return n;
    endfunction

    function automatic bit mdl_borrow(mdl_t s, bit e);
        return s.run && e && (s.count == 1) && (s.pc == PS - 1);
    endfunction

    // Advance every model by one edge using the inputs currently driven, then wait past the edge.
    task automatic tick();
        mdl_t lo_prev;
        lo_prev = c_lo;
        m    = mdl_next(m, rst, abort, load, int'(load_val), reload, en);
        c_lo = mdl_next(c_lo, c_rst, 1'b0, c_load, int'(c_lo_val), 1'b1, 1'b1);
        c_up = mdl_next(c_up, c_rst, 1'b0, c_load, int'(c_up_val), 1'b1, mdl_borrow(lo_prev, 1'b1));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; abort = 1'b0; en = 1'b1; reload = 1'b0; load_val = 16'd7;
        tick();
        tick();
        checks++;
        if (count_val !== 16'd0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset: got count=%0d busy=%b done=%b want 0/0/0", count_val, busy, done);
        else passed++;
        rst = 1'b0; en = 1'b0;
        tick();
        checks++;
        if (count_val !== 16'd0 || busy !== 1'b0)
            $display("FAIL reset_idle: got count=%0d busy=%b want 0/0", count_val, busy);
        else passed++;
    endtask

    task automatic test_one_shot();
        int done_at;
        done_at = -1;
        reload = 1'b0; load_val = 16'd5; load = 1'b1; en = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (count_val !== 16'd5 || busy !== 1'b1)
            $display("FAIL one_shot_load: got count=%0d busy=%b want 5/1", count_val, busy);
        else passed++;
        for (int i = 1; i <= 5 * PS + 2; i++) begin
            #1;
            checks++;
            if (borrow !== mdl_borrow(m, en))
                $display("FAIL one_shot_borrow c%0d: got %b want %b", i, borrow, mdl_borrow(m, en));
            else passed++;
            tick();
            checks++;
            if (count_val !== 16'(m.count) || busy !== m.run || done !== m.done)
                $display("FAIL one_shot c%0d: got %0d/%b/%b want %0d/%b/%b",
                         i, count_val, busy, done, m.count, m.run, m.done);
            else passed++;
            if (done === 1'b1 && done_at < 0) done_at = i;
        end
        checks++;
        if (done_at !== 5 * PS)
            $display("FAIL one_shot_done_tick: got %0d want %0d", done_at, 5 * PS);
        else passed++;
    endtask

    task automatic test_reload();
        int vals[2];
        int pulses;
        vals[0] = 3;
        vals[1] = int'($urandom_range(2, 6));
        for (int k = 0; k < 2; k++) begin
            pulses = 0;
            reload = 1'b1; load_val = 16'(vals[k]); load = 1'b1; en = 1'b1;
            tick();
            load = 1'b0;
            for (int i = 1; i <= 3 * vals[k] * PS; i++) begin
                #1;
                checks++;
                if (borrow !== mdl_borrow(m, en))
                    $display("FAIL reload_borrow v%0d c%0d: got %b want %b", vals[k], i, borrow, mdl_borrow(m, en));
                else passed++;
                tick();
                checks++;
                if (count_val !== 16'(m.count) || busy !== 1'b1 || done !== m.done)
                    $display("FAIL reload v%0d c%0d: got %0d/%b/%b want %0d/1/%b",
                             vals[k], i, count_val, busy, done, m.count, m.done);
                else passed++;
                if (done === 1'b1) pulses++;
            end
            checks++;
            if (pulses !== 3)
                $display("FAIL reload_pulses v%0d: got %0d want 3", vals[k], pulses);
            else passed++;
        end
    endtask

    task automatic test_zero_load();
        reload = 1'($urandom_range(0, 1)); load_val = 16'd0; load = 1'b1; en = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || count_val !== 16'd0)
            $display("FAIL zero_load: got count=%0d busy=%b done=%b want 0/0/1", count_val, busy, done);
        else passed++;
        for (int i = 1; i <= 6; i++) begin
            en = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (borrow !== 1'b0)
                $display("FAIL zero_idle_borrow c%0d: got %b want 0", i, borrow);
            else passed++;
            tick();
            checks++;
            if (count_val !== 16'(m.count) || busy !== m.run || done !== m.done)
                $display("FAIL zero_idle c%0d: got %0d/%b/%b want %0d/%b/%b",
                         i, count_val, busy, done, m.count, m.run, m.done);
            else passed++;
        end
    endtask

    task automatic test_en_gaps_abort();
        int en_ticks, done_ticks;
        en_ticks = 0; done_ticks = -1;
        reload = 1'b0; load_val = 16'd4; load = 1'b1; en = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 8 * PS + 4; i++) begin
            en = (i % 2 == 0);
            #1;
            checks++;
            if (borrow !== mdl_borrow(m, en))
                $display("FAIL gaps_borrow c%0d: got %b want %b", i, borrow, mdl_borrow(m, en));
            else passed++;
            if (en) en_ticks++;
            tick();
            checks++;
            if (count_val !== 16'(m.count) || busy !== m.run || done !== m.done)
                $display("FAIL gaps c%0d: got %0d/%b/%b want %0d/%b/%b",
                         i, count_val, busy, done, m.count, m.run, m.done);
            else passed++;
            if (done === 1'b1 && done_ticks < 0) done_ticks = en_ticks;
        end
        checks++;
        if (done_ticks !== 4 * PS)
            $display("FAIL gaps_done_ticks: got %0d want %0d", done_ticks, 4 * PS);
        else passed++;
        load_val = 16'd4; load = 1'b1; en = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 10 * PS && m.count != 2; i++) tick();
        checks++;
        if (count_val !== 16'd2)
            $display("FAIL abort_setup: got count=%0d want 2", count_val);
        else passed++;
        abort = 1'b1; load = 1'b1; load_val = 16'($urandom_range(1, 9));
        tick();
        abort = 1'b0; load = 1'b0;
        checks++;
        if (count_val !== 16'd0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL abort_load: got count=%0d busy=%b done=%b want 0/0/0", count_val, busy, done);
        else passed++;
        tick();
        checks++;
        if (count_val !== 16'(m.count) || busy !== m.run || done !== m.done)
            $display("FAIL abort_after: got %0d/%b/%b want %0d/%b/%b",
                     count_val, busy, done, m.count, m.run, m.done);
        else passed++;
    endtask

    task automatic test_cascade();
        int up_done_at;
        up_done_at = -1;
        c_rst = 1'b1;
        tick();
        c_rst = 1'b0; c_lo_val = 4'd15; c_up_val = 4'd2; c_load = 1'b1;
        tick();
        c_load = 1'b0;
        for (int i = 1; i <= 30 * PS * PS + 2; i++) begin
            #1;
            checks++;
            if (lo_borrow !== mdl_borrow(c_lo, 1'b1))
                $display("FAIL cascade_lo_borrow c%0d: got %b want %b", i, lo_borrow, mdl_borrow(c_lo, 1'b1));
            else passed++;
            tick();
            checks++;
            if (up_count !== 4'(c_up.count) || up_done !== c_up.done || lo_count !== 4'(c_lo.count))
                $display("FAIL cascade c%0d: got up=%0d/%b lo=%0d want up=%0d/%b lo=%0d",
                         i, up_count, up_done, lo_count, c_up.count, c_up.done, c_lo.count);
            else passed++;
            if (up_done === 1'b1 && up_done_at < 0) up_done_at = i;
        end
        checks++;
        if (up_done_at !== 30 * PS * PS)
            $display("FAIL cascade_done_cycle: got %0d want %0d", up_done_at, 30 * PS * PS);
        else passed++;
        c_rst = 1'b1;
    endtask

    task automatic test_reset_midrun();
        int n;
        reload = 1'b0; load_val = 16'd5; load = 1'b1; en = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 10 * PS && m.count != 2; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (count_val !== 16'd0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_midrun: got count=%0d busy=%b done=%b want 0/0/0", count_val, busy, done);
        else passed++;
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_midrun_after: got busy=%b done=%b want 0/0", busy, done);
        else passed++;
        n = -1;
        load_val = 16'd2; load = 1'b1; en = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 1; i <= 4 * PS + 4; i++) begin
            tick();
            if (done === 1'b1 && n < 0) n = i;
        end
        checks++;
        if (n !== 2 * PS)
            $display("FAIL prescale_done_ticks: got %0d want %0d", n, 2 * PS);
        else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 63) == 0);
            abort    = ($urandom_range(0, 31) == 0);
            load     = ($urandom_range(0, 5) == 0);
            load_val = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 5));
            reload   = 1'($urandom_range(0, 1));
            en       = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (borrow !== mdl_borrow(m, en))
                $display("FAIL random_borrow c%0d: got %b want %b", i, borrow, mdl_borrow(m, en));
            else passed++;
            tick();
            checks++;
            if (count_val !== 16'(m.count) || busy !== m.run || done !== m.done)
                $display("FAIL random c%0d: got %0d/%b/%b want %0d/%b/%b",
                         i, count_val, busy, done, m.count, m.run, m.done);
            else passed++;
        end
        rst = 1'b0; abort = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; abort = 1'b0; en = 1'b0; reload = 1'b0; load_val = 16'd0;
        c_rst = 1'b1; c_load = 1'b0; c_lo_val = 4'd0; c_up_val = 4'd0;
        test_reset();
        test_one_shot();
        test_reload();
        test_zero_load();
        test_en_gaps_abort();
        test_cascade();
        test_reset_midrun();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
